// File: rtl/simd_operand_feeder_if.sv
// Bus between the operand feeder and its neighbours. The load port and the
// command port face the memory-controller side. The remaining outputs face
// the SIMD core.
//
// Handshake: every *valid* / strobe signal is valid-only with no ready.
//   - start: sampled only when the feeder is idle.
//   - load_we: honoured only when the feeder is idle.
//   - valid_instruction / valid_data: single-cycle qualifiers.
//     The core must accept a beat in every cycle where one is asserted.
//     The feeder never stalls once a stream has begun.
interface simd_operand_feeder_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128
);
    // load port
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data_a;
    logic [DATA_W-1:0] load_data_b;
    logic              load_reject;
    // command port
    logic              start;
    logic [2:0]        cmd_instruction;
    logic [ADDR_W-1:0] cmd_base_addr;
    logic [5:0]        cmd_count;
    logic              busy;
    logic              done;
    // core-facing stream
    logic              valid_instruction;
    logic [2:0]        instruction;
    logic [5:0]        data_size;
    logic              valid_data;
    logic [DATA_W-1:0] mc_data_in_opa;
    logic [DATA_W-1:0] mc_data_in_opb;

    // side that issues loads/commands and observes the stream
    modport master (
        output load_we, load_addr, load_data_a, load_data_b,
        output start, cmd_instruction, cmd_base_addr, cmd_count,
        input  load_reject, busy, done,
        input  valid_instruction, instruction, data_size,
        input  valid_data, mc_data_in_opa, mc_data_in_opb
    );

    // the feeder itself
    modport slave (
        input  load_we, load_addr, load_data_a, load_data_b,
        input  start, cmd_instruction, cmd_base_addr, cmd_count,
        output load_reject, busy, done,
        output valid_instruction, instruction, data_size,
        output valid_data, mc_data_in_opa, mc_data_in_opb
    );
endinterface

// File: rtl/simd_operand_feeder.sv
// Operand feeder for the SIMD core.
// Two banks (A, B) share one address and are written through the load port
// while idle. A start command produces one instruction beat, then
// cmd_count back-to-back operand pairs, then a done pulse.
// All bus outputs are registered. The bank read register is the operand
// output register.
module simd_operand_feeder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    simd_operand_feeder_if.slave bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INSTR  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;        // next bank address to read
    logic [5:0]        remaining;  // beats still to be issued

    logic [DATA_W-1:0] bank_a [DEPTH];
    logic [DATA_W-1:0] bank_b [DEPTH];

    assign dbg_state = state;

    // Bank write port. The banks have no reset so their contents survive it.
    // Writes land only while idle. This includes the cycle carrying start,
    // so that word is already visible to the first read of the stream.
    always_ff @(posedge clk) begin
        if (!reset && bus.load_we && state == S_IDLE) begin
            bank_a[bus.load_addr] <= bus.load_data_a;
            bank_b[bus.load_addr] <= bus.load_data_b;
        end
    end

    // Command FSM with registered outputs. Pulse outputs default low each
    // cycle. The INSTR and STREAM states share the beat-issue logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= S_IDLE;
            ptr                   <= '0;
            remaining             <= '0;
            bus.load_reject       <= 1'b0;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
            bus.valid_instruction <= 1'b0;
            bus.instruction       <= '0;
            bus.data_size         <= '0;
            bus.valid_data        <= 1'b0;
            bus.mc_data_in_opa    <= '0;
            bus.mc_data_in_opb    <= '0;
        end else begin
            bus.load_reject       <= bus.load_we && (state != S_IDLE);
            bus.done              <= 1'b0;
            bus.valid_instruction <= 1'b0;
            bus.valid_data        <= 1'b0;
            bus.mc_data_in_opa    <= '0;
            bus.mc_data_in_opb    <= '0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state                 <= S_INSTR;
                        bus.busy              <= 1'b1;
                        bus.valid_instruction <= 1'b1;
                        bus.instruction       <= bus.cmd_instruction;
                        bus.data_size         <= bus.cmd_count;
                        ptr                   <= bus.cmd_base_addr;
                        remaining             <= bus.cmd_count;
                    end
                end
                S_INSTR, S_STREAM: begin
                    if (remaining == 6'd0) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state              <= S_STREAM;
                        bus.valid_data     <= 1'b1;
                        bus.mc_data_in_opa <= bank_a[ptr];
                        bus.mc_data_in_opb <= bank_b[ptr];
                        // pointer wraps naturally: DEPTH is 2**ADDR_W
                        ptr                <= ptr + ADDR_W'(1);
                        remaining          <= remaining - 6'd1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
